// File: rtl/dbus_mem_slave_if.sv
// dbus_mem_slave_if: request/response bundle between a data-bus master and
// the dbus_mem_slave memory model.
// Ports: req_* (one request per cycle, no backpressure), rd_* (read return).
//   master modport drives requests and receives read returns;
//   slave modport receives requests and drives read returns.
interface dbus_mem_slave_if #(
  parameter int NTHR  = 4,
  parameter int TID_W = (NTHR > 1) ? $clog2(NTHR) : 1
);
  // Request channel
  logic             req_valid;
  logic             req_wr;
  logic [TID_W-1:0] req_tid;
  logic [31:0]      req_add;
  logic [1:0]       req_width;
  logic [31:0]      req_wdata;

  // Read return channel
  logic             rd_valid;
  logic [TID_W-1:0] rd_tid;
  logic [31:0]      rd_data;

  modport master (
    output req_valid, req_wr, req_tid, req_add, req_width, req_wdata,
    input  rd_valid, rd_tid, rd_data
  );

  modport slave (
    input  req_valid, req_wr, req_tid, req_add, req_width, req_wdata,
    output rd_valid, rd_tid, rd_data
  );
endinterface

// File: rtl/dbus_mem_slave.sv
// dbus_mem_slave: byte-addressable memory model for a multithreaded data bus,
// with per-thread mailbox stacks at address 0 and a test-status mailbox.
// Latency: reads return exactly LAT cycles after acceptance; writes commit at
// the acceptance edge. No backpressure: every valid request is accepted.
// Ports:
//   clk, rstn         clock and asynchronous active-low reset
//   bus (slave)       req_* request channel, rd_* read-return channel
//   err_misalign      one-cycle pulse after a misaligned access
//   err_stack         one-cycle pulse after a stack overflow/underflow
//   pass_cnt          saturating count of PASS_CODE status writes
//   pass, fail        sticky test verdict flags
module dbus_mem_slave #(
  parameter int          ADDR_W      = 20,
  parameter int          LAT         = 2,
  parameter int          NTHR        = 4,
  parameter int          STK_DEPTH   = 16,
  parameter logic [31:0] STATUS_ADDR = 32'h1001200C,
  parameter logic [31:0] PASS_CODE   = 32'h00400000,
  parameter logic [31:0] FAIL_CODE   = 32'h00080000,
  parameter int          PASS_NEEDED = 2
) (
  input  logic            clk,
  input  logic            rstn,
  dbus_mem_slave_if.slave bus,
  output logic            err_misalign,
  output logic            err_stack,
  output logic [7:0]      pass_cnt,
  output logic            pass,
  output logic            fail
);

  localparam int TID_W     = (NTHR > 1) ? $clog2(NTHR) : 1;
  // Stack pointer must be able to hold STK_DEPTH itself (the "full" value).
  localparam int SP_W      = $clog2(STK_DEPTH + 1);
  localparam int STK_IW    = (STK_DEPTH > 1) ? $clog2(STK_DEPTH) : 1;
  localparam int MEM_BYTES = 1 << ADDR_W;

  // ---------------------------------------------------------------------------
  // Storage (never reset: contents survive rstn)
  // ---------------------------------------------------------------------------
  logic [7:0]  mem     [MEM_BYTES];
  logic [31:0] stk_mem [NTHR][STK_DEPTH];

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic acc_rd;
  logic acc_wr;
  logic is_stk;
  logic is_status;
  logic mem_we;

  assign acc_wr    = bus.req_valid &  bus.req_wr;
  assign acc_rd    = bus.req_valid & ~bus.req_wr;
  // Only the literal address 0 selects the stack; aliases of memory byte 0
  // (e.g. 2^ADDR_W) still reach memory.
  assign is_stk    = (bus.req_add == 32'h0);
  assign is_status = (bus.req_add == STATUS_ADDR);
  assign mem_we    = acc_wr & ~is_stk;

  // Byte lane enables; width 3 behaves as a word.
  logic [3:0] be;
  always_comb begin
    be = 4'b1111;
    unique case (bus.req_width)
      2'd0:    be = 4'b0001;
      2'd1:    be = 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // Per-lane byte addresses, wrapping modulo 2^ADDR_W.
  logic [ADDR_W-1:0] ba [4];
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      ba[k] = bus.req_add[ADDR_W-1:0] + ADDR_W'(k);
    end
  end

  // Misalignment: half on odd byte, word (or width 3) off a 4-byte boundary.
  // The access is still carried out; only the pulse is raised.
  logic mis_d;
  always_comb begin
    mis_d = 1'b0;
    if (bus.req_valid) begin
      if (bus.req_width == 2'd1)
        mis_d = bus.req_add[0];
      else if (bus.req_width[1])
        mis_d = (bus.req_add[1:0] != 2'b00);
    end
  end

  // ---------------------------------------------------------------------------
  // Byte memory: write at acceptance edge, read sampled at acceptance edge.
  // Reads always return four bytes regardless of width.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem[ba[k]] <= bus.req_wdata[8*k +: 8];
      end
    end
  end

  logic [31:0] mem_rdata;
  assign mem_rdata = {mem[ba[3]], mem[ba[2]], mem[ba[1]], mem[ba[0]]};

  // ---------------------------------------------------------------------------
  // Per-thread mailbox stacks
  // ---------------------------------------------------------------------------
  logic [SP_W-1:0]   sp_q [NTHR];
  logic [SP_W-1:0]   sp_sel;
  logic [SP_W-1:0]   sp_d;
  logic [STK_IW-1:0] push_idx;
  logic [STK_IW-1:0] pop_idx;
  logic              stk_full;
  logic              stk_empty;
  logic              push_ok;
  logic              pop_ok;
  logic              serr_d;
  logic [31:0]       stk_top;

  assign sp_sel    = sp_q[bus.req_tid];
  assign stk_full  = (sp_sel == SP_W'(STK_DEPTH));
  assign stk_empty = (sp_sel == '0);
  assign push_ok   = acc_wr & is_stk & ~stk_full;
  assign pop_ok    = acc_rd & is_stk & ~stk_empty;
  // Rejected push/pop leave the pointer alone and only raise the error pulse.
  assign serr_d    = is_stk & ((acc_wr & stk_full) | (acc_rd & stk_empty));

  assign push_idx  = sp_sel[STK_IW-1:0];
  assign pop_idx   = STK_IW'(sp_sel - 1'b1);
  assign stk_top   = stk_mem[bus.req_tid][pop_idx];

  always_comb begin
    sp_d = sp_sel;
    if (push_ok)
      sp_d = sp_sel + 1'b1;
    else if (pop_ok)
      sp_d = sp_sel - 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int t = 0; t < NTHR; t++) sp_q[t] <= '0;
    end else if (push_ok || pop_ok) begin
      sp_q[bus.req_tid] <= sp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) stk_mem[bus.req_tid][push_idx] <= bus.req_wdata;
  end

  // ---------------------------------------------------------------------------
  // Read return pipeline: stage 0 loads at the acceptance edge, so the output
  // of stage LAT-1 appears exactly LAT cycles after the request cycle.
  // ---------------------------------------------------------------------------
  logic                  rd_vld_d;
  logic [31:0]           rd_dat_d;
  logic [LAT-1:0]        pv_q;
  logic [LAT-1:0][TID_W-1:0] pt_q;
  logic [LAT-1:0][31:0]  pd_q;

  assign rd_vld_d = acc_rd;

  always_comb begin
    rd_dat_d = mem_rdata;
    if (is_stk)
      rd_dat_d = pop_ok ? stk_top : 32'h0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pv_q <= '0;
      pt_q <= '0;
      pd_q <= '0;
    end else begin
      pv_q[0] <= rd_vld_d;
      pt_q[0] <= bus.req_tid;
      pd_q[0] <= rd_dat_d;
      for (int i = 1; i < LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        pt_q[i] <= pt_q[i-1];
        pd_q[i] <= pd_q[i-1];
      end
    end
  end

  assign bus.rd_valid = pv_q[LAT-1];
  assign bus.rd_tid   = pt_q[LAT-1];
  assign bus.rd_data  = pd_q[LAT-1];

  // ---------------------------------------------------------------------------
  // Status mailbox and error pulses
  // ---------------------------------------------------------------------------
  logic       status_wr;
  logic [7:0] pass_cnt_q;
  logic [7:0] pass_cnt_d;
  logic       pass_q;
  logic       pass_d;
  logic       fail_q;
  logic       fail_d;
  logic       mis_q;
  logic       serr_q;

  assign status_wr = acc_wr & is_status;

  always_comb begin
    pass_cnt_d = pass_cnt_q;
    if (status_wr && (bus.req_wdata == PASS_CODE) && (pass_cnt_q != 8'hFF))
      pass_cnt_d = pass_cnt_q + 8'd1;
  end

  // Both verdicts are sticky; they only ever clear through reset.
  assign pass_d = pass_q | (32'(pass_cnt_d) >= PASS_NEEDED);
  assign fail_d = fail_q | (status_wr & (bus.req_wdata == FAIL_CODE));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pass_cnt_q <= '0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      mis_q      <= 1'b0;
      serr_q     <= 1'b0;
    end else begin
      pass_cnt_q <= pass_cnt_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      mis_q      <= mis_d;
      serr_q     <= serr_d;
    end
  end

  assign pass_cnt     = pass_cnt_q;
  assign pass         = pass_q;
  assign fail         = fail_q;
  assign err_misalign = mis_q;
  assign err_stack    = serr_q;

endmodule
